// File: rtl/alu_pkg.sv
// Shared ALU command definitions: operand/opcode widths, illegal opcodes and
// the command record passed between command sources and the issue queue.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ILLEGAL_0 = 4'b1100;
    localparam logic [OP_W-1:0] OP_ILLEGAL_1 = 4'b1101;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
    } alu_cmd_t;

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op == OP_ILLEGAL_0) || (op == OP_ILLEGAL_1);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands; head entry is visible combinationally on
// dout, and occupancy is tracked separately from the wrapping pointers.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  alu_cmd_t      din,
    input  logic          pop,
    output alu_cmd_t      dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    alu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is left unreset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU command buffer and issue stage: filters illegal opcodes, queues commands,
// issues one per cycle into registered ALU inputs and aligns a result strobe.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int OP_W    = alu_pkg::OP_W,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 3,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic              hold,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [OP_W-1:0]   s,
    output logic              issue_valid,
    output logic [TAG_W-1:0]  issue_tag,
    output logic              res_valid,
    output logic [TAG_W-1:0]  res_tag,
    output logic              err_illegal,
    output logic [CW-1:0]     count
);

    alu_cmd_t in_cmd;
    alu_cmd_t head;
    logic     accept;
    logic     illegal;
    logic     full;
    logic     empty;
    logic     issue;

    logic [ALU_LAT:1]            vld_pipe;
    logic [ALU_LAT:1][TAG_W-1:0] tag_pipe;

    assign in_cmd   = '{op: in_op, a: in_a, b: in_b, c: in_c};
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign illegal  = op_is_illegal(in_op);
    assign issue    = !empty && !hold;

    // Illegal commands complete the handshake but never reach the FIFO.
    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && !illegal),
        .din   (in_cmd),
        .pop   (issue),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a           <= '0;
            b           <= '0;
            c           <= '0;
            s           <= '0;
            issue_tag   <= '0;
            issue_valid <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            issue_valid <= issue;
            err_illegal <= accept && illegal;
            if (issue) begin
                a         <= head.a;
                b         <= head.b;
                c         <= head.c;
                s         <= head.op;
                issue_tag <= issue_tag + 1'b1;
            end
        end
    end

    // Free-running delay line matching the ALU latency; hold never stalls it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue_valid;
            tag_pipe[1] <= issue_tag;
            for (int i = 2; i <= ALU_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign res_valid = vld_pipe[ALU_LAT];
    assign res_tag   = tag_pipe[ALU_LAT];

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: table-driven pushes, a scoreboard of
// expected issues, and hand-written fill/illegal/wrap/reset sequences.
module tb_alu_issue_queue;

    localparam int DW = 16;
    localparam int OW = 4;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_op;
    logic [DW-1:0] in_a, in_b, in_c;
    logic          hold;
    logic [DW-1:0] a, b, c;
    logic [OW-1:0] s;
    logic          issue_valid;
    logic [TW-1:0] issue_tag;
    logic          res_valid;
    logic [TW-1:0] res_tag;
    logic          err_illegal;
    logic [2:0]    count;

    alu_issue_queue #(.DEPTH(4), .ALU_LAT(1), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c), .hold(hold),
        .a(a), .b(b), .c(c), .s(s), .issue_valid(issue_valid),
        .issue_tag(issue_tag), .res_valid(res_valid), .res_tag(res_tag),
        .err_illegal(err_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a, b, c;
    } exp_t;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a, b, c;
        logic          bad;
    } vec_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] exp_tag = '0;
    logic          prev_iv = 1'b0;
    logic [TW-1:0] prev_tag = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every issue pops the oldest expected command; results trail by one cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_tag = '0;
            prev_iv = 1'b0;
        end else begin
            if (prev_iv || res_valid) begin
                chk("res_valid", 32'(res_valid), 32'(prev_iv));
                if (prev_iv) chk("res_tag", 32'(res_tag), 32'(prev_tag));
            end
            if (issue_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_issue", 32'(issue_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    exp_tag = exp_tag + 1'b1;
                    chk("issue_s", 32'(s), 32'(e.op));
                    chk("issue_a", 32'(a), 32'(e.a));
                    chk("issue_b", 32'(b), 32'(e.b));
                    chk("issue_c", 32'(c), 32'(e.c));
                    chk("issue_tag", 32'(issue_tag), 32'(exp_tag));
                end
            end
            prev_iv  = issue_valid;
            prev_tag = exp_tag;
        end
    end

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic push_cmd(input logic [OW-1:0] op, input logic [DW-1:0] va,
                            input logic [DW-1:0] vb, input logic [DW-1:0] vc, input logic bad);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = va; in_b = vb; in_c = vc;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", 32'(in_ready), 32'd1);
        if (!bad) sb.push_back('{op: op, a: va, b: vb, c: vc});
        @(negedge clk);
        in_valid = 1'b0;
        chk("err_illegal", 32'(err_illegal), 32'(bad));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_abc", {a ^ b, c}, 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_s_tags", {s, issue_tag, res_tag}, 32'd0);
        chk("rst_strobes", {issue_valid, res_valid, err_illegal}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Called at a negedge: assert reset mid-cycle, check it lands without an edge.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        in_valid = 1'b0;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{op: 4'd0,  a: 16'h2948, b: 16'h0000, c: 16'h762D, bad: 1'b0};
        vecs[1] = '{op: 4'd11, a: 16'hFFFF, b: 16'h0001, c: 16'h8000, bad: 1'b0};
        vecs[2] = '{op: 4'd12, a: 16'h1234, b: 16'h5678, c: 16'h9ABC, bad: 1'b1};
        vecs[3] = '{op: 4'd14, a: 16'h0000, b: 16'hFFFF, c: 16'h0000, bad: 1'b0};
        vecs[4] = '{op: 4'd13, a: 16'hDEAD, b: 16'hBEEF, c: 16'hCAFE, bad: 1'b1};
        vecs[5] = '{op: 4'd15, a: 16'hA5A5, b: 16'h5A5A, c: 16'h0F0F, bad: 1'b0};
        vecs[6] = '{op: 4'd7,  a: 16'h0001, b: 16'h0002, c: 16'h0003, bad: 1'b0};
        vecs[7] = '{op: 4'd1,  a: 16'h7FFF, b: 16'h8000, c: 16'hFFFE, bad: 1'b0};

        rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_c = '0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // single command with explicit latency checks
        push_cmd(4'd0, 16'h2948, 16'h0000, 16'h762D, 1'b0);
        @(negedge clk);
        chk("single_iv", 32'(issue_valid), 32'd1);
        chk("single_a", 32'(a), 32'h2948);
        chk("single_c", 32'(c), 32'h762D);
        chk("single_s", 32'(s), 32'd0);
        chk("single_tag", 32'(issue_tag), 32'd1);
        @(negedge clk);
        chk("single_res_valid", 32'(res_valid), 32'd1);
        chk("single_res_tag", 32'(res_tag), 32'd1);
        drain();

        // table vectors, back to back
        for (int i = 0; i < 8; i++)
            push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].bad);
        drain();

        // fill while held, then drain on consecutive cycles
        hold = 1'b1;
        for (int i = 1; i <= 4; i++)
            push_cmd(OW'(i), DW'(16'h1000 + i), DW'(i), DW'(16'hF000 - i), 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_op = 4'd5; in_a = 16'h1005; in_b = 16'h0005; in_c = 16'hEFFB;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_count", 32'(count), 32'd4);
        end
        hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_consec", 32'(issue_valid), 32'd1);
            if (i == 0) begin
                chk("op5_ready", 32'(in_ready), 32'd1);
                sb.push_back('{op: 4'd5, a: 16'h1005, b: 16'h0005, c: 16'hEFFB});
            end
            if (i == 1) in_valid = 1'b0;
        end
        drain();

        // illegal op in the middle of a burst
        push_cmd(4'd2, 16'h0002, 16'h0020, 16'h0200, 1'b0);
        push_cmd(4'd12, 16'h0C0C, 16'h0C0C, 16'h0C0C, 1'b1);
        push_cmd(4'd3, 16'h0003, 16'h0030, 16'h0300, 1'b0);
        drain();

        // simultaneous push/pop at count=2 and tag wrap from a fresh reset
        mid_reset();
        hold = 1'b1;
        push_cmd(4'd8, 16'h0800, 16'h0008, 16'h8000, 1'b0);
        push_cmd(4'd9, 16'h0900, 16'h0009, 16'h9000, 1'b0);
        chk("pp_count_pre", 32'(count), 32'd2);
        hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_cmd(OW'(i % 12), DW'(16'hA000 + i), DW'(i * 3), DW'(16'h5000 - i), 1'b0);
            chk("pp_count", 32'(count), 32'd2);
        end
        drain();
        chk("wrap_tag", 32'(issue_tag), 32'd4);

        // reset mid-burst with count=3 and one command in the result pipe
        hold = 1'b1;
        for (int i = 0; i < 4; i++)
            push_cmd(4'd6, DW'(16'h6000 + i), 16'h0006, 16'h0060, 1'b0);
        hold = 1'b0;
        @(negedge clk);
        hold = 1'b1;
        chk("mb_count", 32'(count), 32'd3);
        chk("mb_issue", 32'(issue_valid), 32'd1);
        mid_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mb_quiet", {issue_valid, res_valid}, 32'd0);
        end
        push_cmd(4'd10, 16'hBEEF, 16'h0A0A, 16'h1111, 1'b0);
        @(negedge clk);
        chk("mb_next_tag", 32'(issue_tag), 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
